// File: rtl/sram_banked_dp_pkg.sv
// rtl/sram_banked_dp_pkg.sv - shared types for the banked dual-port SRAM
package sram_banked_dp_pkg;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    function automatic pri_e other_port(input pri_e p);
        return (p == PRI_A) ? PRI_B : PRI_A;
    endfunction

endpackage

// File: rtl/sram_banked_dp_bank.sv
// rtl/sram_banked_dp_bank.sv - single-port synchronous RAM bank, byte-enabled write, 1-cycle read
module sram_banked_dp_bank #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 12
) (
    input  logic                  iClk,
    input  logic                  iEn,
    input  logic                  iWr,
    input  logic [DATA_W/8-1:0]   iBE,
    input  logic [ROW_W-1:0]      iRow,
    input  logic [DATA_W-1:0]     iWData,
    output logic [DATA_W-1:0]     oRData
);
    localparam int DEPTH = 2 ** ROW_W;
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are never reset; rdata_q keeps the last read word while idle.
    always_ff @(posedge iClk) begin
        if (iEn) begin
            if (iWr) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (iBE[i]) begin
                        mem_q[iRow][i*8 +: 8] <= iWData[i*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[iRow];
            end
        end
    end

    assign oRData = rdata_q;

endmodule

// File: rtl/sram_banked_dp.sv
// rtl/sram_banked_dp.sv - dual-port SRAM over interleaved single-port banks with round-robin arbitration
module sram_banked_dp
    import sram_banked_dp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 14,
    parameter int NUM_BANKS = 4,
    parameter int OUT_REG   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iReqA,
    input  logic                 iWrA,
    input  logic [DATA_W/8-1:0]  iBEA,
    input  logic [ADDR_W-1:0]    iAddrA,
    input  logic [DATA_W-1:0]    iWDataA,
    input  logic                 iReqB,
    input  logic                 iWrB,
    input  logic [DATA_W/8-1:0]  iBEB,
    input  logic [ADDR_W-1:0]    iAddrB,
    input  logic [DATA_W-1:0]    iWDataB,
    output logic                 oGntA,
    output logic                 oGntB,
    output logic                 oRValidA,
    output logic                 oRValidB,
    output logic [DATA_W-1:0]    oRDataA,
    output logic [DATA_W-1:0]    oRDataB,
    output logic [CNT_W-1:0]     oConflictCnt
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int RD_LAT = 1 + OUT_REG;

    logic [BANK_W-1:0] bank_a, bank_b;
    logic [ROW_W-1:0]  row_a, row_b;
    logic              collision, gnt_a, gnt_b;
    pri_e              pri_q;
    logic [CNT_W-1:0]  cnt_q;

    assign bank_a    = iAddrA[BANK_W-1:0];
    assign bank_b    = iAddrB[BANK_W-1:0];
    assign row_a     = iAddrA[ADDR_W-1:BANK_W];
    assign row_b     = iAddrB[ADDR_W-1:BANK_W];
    assign collision = iReqA & iReqB & (bank_a == bank_b);
    assign gnt_a     = iReqA & ~(collision & (pri_q == PRI_B));
    assign gnt_b     = iReqB & ~(collision & (pri_q == PRI_A));
    assign oGntA     = gnt_a;
    assign oGntB     = gnt_b;

    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    // Grants never select the same bank for both ports, so A-first muxing is safe.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel_a, sel_b;
        assign sel_a = gnt_a & (bank_a == BANK_W'(b));
        assign sel_b = gnt_b & (bank_b == BANK_W'(b));

        sram_banked_dp_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .iClk   (iClk),
            .iEn    (sel_a | sel_b),
            .iWr    (sel_a ? iWrA    : iWrB),
            .iBE    (sel_a ? iBEA    : iBEB),
            .iRow   (sel_a ? row_a   : row_b),
            .iWData (sel_a ? iWDataA : iWDataB),
            .oRData (bank_rdata[b])
        );
    end

    logic [1:0]        rv_a_q, rv_b_q;
    logic [BANK_W-1:0] bsel_a_q, bsel_b_q;
    logic [DATA_W-1:0] hold_a_q, hold_b_q;
    logic [DATA_W-1:0] rmux_a, rmux_b;

    // Bank outputs are only trusted in the cycle after a read; otherwise keep the last word.
    assign rmux_a = rv_a_q[0] ? bank_rdata[bsel_a_q] : hold_a_q;
    assign rmux_b = rv_b_q[0] ? bank_rdata[bsel_b_q] : hold_b_q;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rv_a_q   <= '0;
            rv_b_q   <= '0;
            bsel_a_q <= '0;
            bsel_b_q <= '0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            pri_q    <= PRI_A;
            cnt_q    <= '0;
        end else begin
            rv_a_q   <= {rv_a_q[0], gnt_a & ~iWrA};
            rv_b_q   <= {rv_b_q[0], gnt_b & ~iWrB};
            bsel_a_q <= bank_a;
            bsel_b_q <= bank_b;
            hold_a_q <= rmux_a;
            hold_b_q <= rmux_b;
            if (collision) begin
                pri_q <= other_port(pri_q);
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign oRValidA     = rv_a_q[RD_LAT-1];
    assign oRValidB     = rv_b_q[RD_LAT-1];
    assign oRDataA      = (OUT_REG != 0) ? hold_a_q : rmux_a;
    assign oRDataB      = (OUT_REG != 0) ? hold_b_q : rmux_b;
    assign oConflictCnt = cnt_q;

endmodule

// File: tb/tb_sram_banked_dp.sv
// tb/tb_sram_banked_dp.sv - directed bench driving an OUT_REG=0 and an OUT_REG=1/CNT_W=4 instance in parallel
module tb_sram_banked_dp;

    logic        iClk, iRst;
    logic        iReqA, iWrA, iReqB, iWrB;
    logic [3:0]  iBEA, iBEB;
    logic [13:0] iAddrA, iAddrB;
    logic [31:0] iWDataA, iWDataB;

    logic        gnt_a0, gnt_b0, rv_a0, rv_b0;
    logic [31:0] rd_a0, rd_b0;
    logic [15:0] cnt0;
    logic        gnt_a1, gnt_b1, rv_a1, rv_b1;
    logic [31:0] rd_a1, rd_b1;
    logic [3:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    sram_banked_dp #(.OUT_REG(0), .CNT_W(16)) dut0 (
        .iClk(iClk), .iRst(iRst),
        .iReqA(iReqA), .iWrA(iWrA), .iBEA(iBEA), .iAddrA(iAddrA), .iWDataA(iWDataA),
        .iReqB(iReqB), .iWrB(iWrB), .iBEB(iBEB), .iAddrB(iAddrB), .iWDataB(iWDataB),
        .oGntA(gnt_a0), .oGntB(gnt_b0), .oRValidA(rv_a0), .oRValidB(rv_b0),
        .oRDataA(rd_a0), .oRDataB(rd_b0), .oConflictCnt(cnt0)
    );

    sram_banked_dp #(.OUT_REG(1), .CNT_W(4)) dut1 (
        .iClk(iClk), .iRst(iRst),
        .iReqA(iReqA), .iWrA(iWrA), .iBEA(iBEA), .iAddrA(iAddrA), .iWDataA(iWDataA),
        .iReqB(iReqB), .iWrB(iWrB), .iBEB(iBEB), .iAddrB(iAddrB), .iWDataB(iWDataB),
        .oGntA(gnt_a1), .oGntB(gnt_b1), .oRValidA(rv_a1), .oRValidB(rv_b1),
        .oRDataA(rd_a1), .oRDataB(rd_b1), .oConflictCnt(cnt1)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic wr, input logic [3:0] be,
                         input logic [13:0] addr, input logic [31:0] data);
        iReqA = req; iWrA = wr; iBEA = be; iAddrA = addr; iWDataA = data;
    endtask

    task automatic set_b(input logic req, input logic wr, input logic [3:0] be,
                         input logic [13:0] addr, input logic [31:0] data);
        iReqB = req; iWrB = wr; iBEB = be; iAddrB = addr; iWDataB = data;
    endtask

    task automatic idle();
        set_a(0, 0, 4'h0, 14'h0, 32'h0);
        set_b(0, 0, 4'h0, 14'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    logic [31:0] t5_data [4];

    initial begin
        iRst = 1'b1;
        idle();
        tick();
        tick();
        iRst = 1'b0;
        #1;
        chk("rst_rv_a1", 32'(rv_a1), 32'h0);
        chk("rst_rv_b1", 32'(rv_b1), 32'h0);
        chk("rst_rd_a1", rd_a1, 32'h0);
        chk("rst_rd_a0", rd_a0, 32'h0);
        chk("rst_cnt1", 32'(cnt1), 32'h0);
        tick();

        // 1: write then read on port A
        set_a(1, 1, 4'hF, 14'h000F, 32'h12345678);
        #1 chk("t1_gnt_wr", 32'(gnt_a1), 32'h1);
        tick();
        set_a(1, 0, 4'hF, 14'h000F, 32'h0);
        #1 chk("t1_gnt_rd", 32'(gnt_a1), 32'h1);
        tick();
        idle();
        chk("t1_rv_a0_lat1", 32'(rv_a0), 32'h1);
        chk("t1_rd_a0", rd_a0, 32'h12345678);
        chk("t1_rv_a1_early", 32'(rv_a1), 32'h0);
        tick();
        chk("t1_rv_a1_lat2", 32'(rv_a1), 32'h1);
        chk("t1_rd_a1", rd_a1, 32'h12345678);
        chk("t1_rv_a0_pulse", 32'(rv_a0), 32'h0);
        chk("t1_rd_a0_hold", rd_a0, 32'h12345678);
        tick();
        chk("t1_rv_a1_pulse", 32'(rv_a1), 32'h0);

        // 2: different banks served together
        set_a(1, 1, 4'hF, 14'h1001, 32'hDEADBEEF);
        set_b(1, 1, 4'hF, 14'h2002, 32'hCAFEF00D);
        #1 chk("t2_gnt_a", 32'(gnt_a1), 32'h1);
        chk("t2_gnt_b", 32'(gnt_b1), 32'h1);
        tick();
        set_a(1, 0, 4'hF, 14'h1001, 32'h0);
        set_b(1, 0, 4'hF, 14'h2002, 32'h0);
        #1 chk("t2_gnt_rd_b", 32'(gnt_b1), 32'h1);
        tick();
        idle();
        tick();
        chk("t2_rv_a1", 32'(rv_a1), 32'h1);
        chk("t2_rv_b1", 32'(rv_b1), 32'h1);
        chk("t2_rd_a1", rd_a1, 32'hDEADBEEF);
        chk("t2_rd_b1", rd_b1, 32'hCAFEF00D);
        chk("t2_rd_b0_hold", rd_b0, 32'hCAFEF00D);
        chk("t2_cnt1", 32'(cnt1), 32'h0);

        // 3: same-bank collision, A has priority, then B
        set_a(1, 0, 4'hF, 14'h0004, 32'h0);
        set_b(1, 1, 4'hF, 14'h0008, 32'h55AA55AA);
        #1 chk("t3_c1_gnt_a", 32'(gnt_a1), 32'h1);
        chk("t3_c1_gnt_b", 32'(gnt_b1), 32'h0);
        chk("t3_c1_gnt_b0", 32'(gnt_b0), 32'h0);
        tick();
        set_a(0, 0, 4'h0, 14'h0, 32'h0);
        #1 chk("t3_c2_gnt_b", 32'(gnt_b1), 32'h1);
        tick();
        chk("t3_cnt1", 32'(cnt1), 32'h1);
        set_a(1, 0, 4'hF, 14'h0008, 32'h0);
        set_b(1, 0, 4'hF, 14'h0004, 32'h0);
        #1 chk("t3_r_gnt_b", 32'(gnt_b1), 32'h1);
        chk("t3_r_gnt_a", 32'(gnt_a1), 32'h0);
        tick();
        set_b(0, 0, 4'h0, 14'h0, 32'h0);
        #1 chk("t3_r2_gnt_a", 32'(gnt_a1), 32'h1);
        tick();
        idle();
        tick();
        chk("t3_rv_a1", 32'(rv_a1), 32'h1);
        chk("t3_rd_a1", rd_a1, 32'h55AA55AA);
        chk("t3_rd_a0_hold", rd_a0, 32'h55AA55AA);
        chk("t3_cnt1_2", 32'(cnt1), 32'h2);
        chk("t3_cnt0_2", 32'(cnt0), 32'h2);

        // 4: partial byte-enable write
        set_a(1, 1, 4'hF, 14'h0123, 32'hAABBCCDD);
        tick();
        set_a(1, 1, 4'b0101, 14'h0123, 32'h11223344);
        tick();
        set_a(1, 0, 4'hF, 14'h0123, 32'h0);
        tick();
        idle();
        tick();
        chk("t4_rd_a1", rd_a1, 32'hAA22CC44);

        // 5: back-to-back reads, both latencies
        t5_data[0] = 32'hA0000000;
        t5_data[1] = 32'hA1111111;
        t5_data[2] = 32'hA2222222;
        t5_data[3] = 32'hA3333333;
        for (int k = 0; k < 4; k++) begin
            set_a(1, 1, 4'hF, 14'(k), t5_data[k]);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_a(1, 0, 4'hF, 14'(k), 32'h0);
            else       idle();
            tick();
            chk($sformatf("t5_rv_a0_%0d", k), 32'(rv_a0), (k < 4) ? 32'h1 : 32'h0);
            if (k < 4) chk($sformatf("t5_rd_a0_%0d", k), rd_a0, t5_data[k]);
            chk($sformatf("t5_rv_a1_%0d", k), 32'(rv_a1), (k >= 1) ? 32'h1 : 32'h0);
            if (k >= 1) chk($sformatf("t5_rd_a1_%0d", k), rd_a1, t5_data[k-1]);
        end
        tick();
        chk("t5_rv_a1_end", 32'(rv_a1), 32'h0);

        // 6: reset with a read in flight, then counter saturation
        set_a(1, 0, 4'hF, 14'h0002, 32'h0);
        tick();
        idle();
        iRst = 1'b1;
        #1;
        chk("t6_rst_rv_a1", 32'(rv_a1), 32'h0);
        chk("t6_rst_rd_a1", rd_a1, 32'h0);
        chk("t6_rst_rv_a0", 32'(rv_a0), 32'h0);
        chk("t6_rst_rd_a0", rd_a0, 32'h0);
        chk("t6_rst_cnt0", 32'(cnt0), 32'h0);
        tick();
        tick();
        iRst = 1'b0;
        tick();
        chk("t6_no_rv_a1", 32'(rv_a1), 32'h0);
        set_a(1, 0, 4'hF, 14'h0000, 32'h0);
        set_b(1, 0, 4'hF, 14'h0004, 32'h0);
        #1 chk("t6_ptr_gnt_a", 32'(gnt_a1), 32'h1);
        chk("t6_ptr_gnt_b", 32'(gnt_b1), 32'h0);
        for (int i = 0; i < 19; i++) begin
            tick();
            if (i == 14) begin
                chk("t6_cnt1_15", 32'(cnt1), 32'hF);
                chk("t6_cnt0_15", 32'(cnt0), 32'd15);
            end
        end
        chk("t6_cnt1_sat", 32'(cnt1), 32'hF);
        chk("t6_cnt0_19", 32'(cnt0), 32'd19);
        chk("t6_end_gnt_b", 32'(gnt_b1), 32'h1);
        chk("t6_end_gnt_a", 32'(gnt_a1), 32'h0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
